ntt_coef_rd_arbiter: RTL

Burst read scheduler that shares the single read port of the NTT coefficient RAM (8-bit address, 3072-bit word, 1-cycle read latency) between several requesters, such as the NTT core, the debug dump unit and the AXI readback path. Each requester asks for a burst of consecutive words. The arbiter grants one requester at a time, generates the RAM addresses itself and steers the returned data to the owner with per-beat valid strobes. It sits directly in front of the coefficient RAM read port and replaces point-to-point wiring of `Coef_RAd`.

---
 rtl/ntt_coef_rd_arbiter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/ntt_coef_rd_arbiter.sv
// Burst read scheduler sharing the NTT coefficient RAM read port between NREQ requesters.
// Round-robin by default; define NTT_ARB_FIXED_PRIO_EN for fixed priority (requester 0 highest).
module ntt_coef_rd_arbiter #(
  parameter int NREQ = 3,
  parameter int AW   = 8,
  parameter int DW   = 3072,
  parameter int LW   = 9
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*LW-1:0] req_len,
  output logic [NREQ-1:0]    gnt,
  output logic               busy,
  output logic [AW-1:0]      Coef_RAd,
  input  logic [DW-1:0]      Coef_RData,
  output logic [DW-1:0]      rd_data,
  output logic [NREQ-1:0]    rd_valid,
  output logic [NREQ-1:0]    done
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BURST,
    S_DRAIN
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   owner_q;
  logic [IW-1:0]   win_idx;
  logic [IW-1:0]   cand;
  logic [AW-1:0]   addr_q;
  logic [AW-1:0]   sel_addr;
  logic [LW-1:0]   rem_q;
  logic [LW-1:0]   sel_len;
  logic [NREQ-1:0] owner_oh;
  logic [NREQ-1:0] rd_valid_q;
`ifndef NTT_ARB_FIXED_PRIO_EN
  logic [IW-1:0]   rr_ptr_q;
`endif

  // Winner search runs from the highest offset down so the lowest offset is the last to assign.
  // NOTE: every always_comb output gets a default first, otherwise an untaken branch infers a latch.
  always_comb begin
    win_idx = '0;
    cand    = '0;
    for (int off = NREQ - 1; off >= 0; off--) begin
`ifdef NTT_ARB_FIXED_PRIO_EN
      cand = IW'(off);
`else
      cand = IW'((int'(rr_ptr_q) + off) % NREQ);
`endif
      if (req[cand]) win_idx = cand;
    end
  end

  always_comb begin
    sel_addr = '0;
    sel_len  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_idx == IW'(i)) begin
        sel_addr = req_addr[i*AW +: AW];
        sel_len  = req_len[i*LW +: LW];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (|req) state_d = (sel_len == '0) ? S_DRAIN : S_BURST;
      end
      S_BURST: begin
        if (rem_q == LW'(1)) state_d = S_DRAIN;
      end
      S_DRAIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      owner_q    <= '0;
      addr_q     <= '0;
      rem_q      <= '0;
      rd_valid_q <= '0;
`ifndef NTT_ARB_FIXED_PRIO_EN
      rr_ptr_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      rd_valid_q <= (state_q == S_BURST) ? owner_oh : '0;
      case (state_q)
        S_IDLE: begin
          if (|req) begin
            owner_q <= win_idx;
            rem_q   <= sel_len;
            if (sel_len != '0) addr_q <= sel_addr;
          end
        end
        S_BURST: begin
          // The address register stops on the last beat so it holds outside BURST.
          if (rem_q != LW'(1)) begin
            addr_q <= addr_q + 1'b1;
            rem_q  <= rem_q - 1'b1;
          end
        end
        S_DRAIN: begin
`ifndef NTT_ARB_FIXED_PRIO_EN
          rr_ptr_q <= (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

  assign owner_oh = NREQ'(1) << owner_q;
  assign busy     = (state_q != S_IDLE);
  assign gnt      = busy ? owner_oh : '0;
  assign done     = (state_q == S_DRAIN) ? owner_oh : '0;
  assign rd_valid = rd_valid_q;
  assign Coef_RAd = addr_q;
  assign rd_data  = Coef_RData;

endmodule
